// File: rtl/pdp8_bus_pkg.sv
// Shared definitions for the PDP-8 style bus bridge.
//   WORD_W / NIB_W / CHAN_W : data word, CPU nibble and channel-number widths
//   OPC_*                   : cpu_out[7:5] encodings of the multiplexed bus
//   bus_op_e / decode_op    : classify one cpu_out byte into a bus operation
package pdp8_bus_pkg;

  localparam int unsigned WORD_W = 12;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CHAN_W = 5;

  // ADDR is 1xx: only bit 7 is significant, bit 6 picks the address half.
  localparam logic [2:0] OPC_ADDR   = 3'b100;
  localparam logic [2:0] OPC_IOSEL  = 3'b011;
  localparam logic [2:0] OPC_WR_LO  = 3'b000;
  localparam logic [2:0] OPC_WR_HI  = 3'b001;
  localparam logic [2:0] OPC_COMMIT = 3'b010;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADDR,
    OP_IOSEL,
    OP_WR_LO,
    OP_WR_HI,
    OP_COMMIT
  } bus_op_e;

  // Data ops (WR_LO/WR_HI/COMMIT) additionally need cpu_out[4]=1; with
  // cpu_out[4]=0 those codes are plain read cycles.
  function automatic bus_op_e decode_op(input logic [7:0] b);
    bus_op_e op;
    op = OP_NONE;
    if (b[7] == OPC_ADDR[2]) begin
      op = OP_ADDR;
    end else if (b[7:5] == OPC_IOSEL) begin
      op = OP_IOSEL;
    end else if (b[4]) begin
      case (b[7:5])
        OPC_WR_LO:  op = OP_WR_LO;
        OPC_WR_HI:  op = OP_WR_HI;
        OPC_COMMIT: op = OP_COMMIT;
        default:    op = OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/pdp8_bus_fifo.sv
// Synchronous FIFO for the bridge output path.
//   clk_i, rst_ni      : clock, async active-low reset (pointers/count only)
//   push_i, data_i     : write request and word; accepted when not full or
//                        when a pop happens in the same cycle
//   pop_i              : consume head (ignored when empty)
//   data_o, valid_o    : head word, not-empty flag
//   full_o             : DEPTH entries held
module pdp8_bus_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop_i && valid_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pdp8_bus_bridge.sv
// Bridge between an 8-bit multiplexed CPU bus and a word memory plus
// IO_CH input channels and an output FIFO.
//   clk, rst_n          : clock, async active-low reset (release synchronised)
//   cpu_out / cpu_in    : CPU command byte in, read nibble out
//   in_data / in_valid  : per-channel input words; in_ack pulses on consume
//   out_valid/out_ready : output FIFO handshake, out_data/out_chan = head
//   fifo_full, overflow : FIFO full, sticky dropped-write flag
module pdp8_bus_bridge
  import pdp8_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned IO_CH      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cpu_out,
  output logic [NIB_W-1:0]      cpu_in,
  input  logic [WORD_W*IO_CH-1:0] in_data,
  input  logic [IO_CH-1:0]      in_valid,
  output logic [IO_CH-1:0]      in_ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic [CHAN_W-1:0]     out_chan,
  output logic                  fifo_full,
  output logic                  overflow
);

  logic [1:0]          rst_sync_q;
  logic                rst_int_n;
  logic [11:0]         addr_q;
  logic [7:0]          tmp_q;
  logic                io_q;
  logic [CHAN_W-1:0]   io_sel_q;
  logic                rd_seen_q;
  logic                overflow_q;
  logic [IO_CH-1:0]    in_ack_q;
  logic [WORD_W-1:0]   mem_q [2**ADDR_W];

  bus_op_e             op;
  logic                sel_ok;
  logic [WORD_W-1:0]   chan_word;
  logic                chan_valid;
  logic [IO_CH-1:0]    ack_mask;
  logic [WORD_W-1:0]   commit_word;
  logic [WORD_W-1:0]   rd_word;
  logic [ADDR_W-1:0]   mem_idx;
  logic                push_req, pop;
  logic [CHAN_W+WORD_W-1:0] fifo_head;

  // Assertion is immediate, release takes two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign op          = decode_op(cpu_out);
  assign sel_ok      = 32'(io_sel_q) < IO_CH;
  assign commit_word = {cpu_out[3:0], tmp_q};
  assign mem_idx     = addr_q[ADDR_W-1:0];

  // Channel mux; an out-of-range io_sel yields a zero word and no valid.
  always_comb begin
    chan_word  = '0;
    chan_valid = 1'b0;
    ack_mask   = '0;
    for (int unsigned k = 0; k < IO_CH; k++) begin
      if (io_sel_q == CHAN_W'(k)) begin
        chan_word   = in_data[WORD_W*k +: WORD_W];
        chan_valid  = in_valid[k];
        ack_mask[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = io_q ? chan_word : mem_q[mem_idx];
    case (cpu_out[6:5])
      2'b00:   cpu_in = rd_word[11:8];
      2'b01:   cpu_in = rd_word[7:4];
      2'b10:   cpu_in = rd_word[3:0];
      default: cpu_in = '0;
    endcase
  end

  assign push_req = (op == OP_COMMIT) && io_q && sel_ok;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      addr_q     <= '0;
      tmp_q      <= '0;
      io_q       <= 1'b0;
      io_sel_q   <= '0;
      rd_seen_q  <= 1'b0;
      overflow_q <= 1'b0;
      in_ack_q   <= '0;
    end else begin
      in_ack_q <= '0;
      case (op)
        OP_ADDR: begin
          if (cpu_out[6]) addr_q[11:6] <= cpu_out[5:0];
          else            addr_q[5:0]  <= cpu_out[5:0];
          if (io_q && rd_seen_q) in_ack_q <= ack_mask;
          io_q      <= 1'b0;
          rd_seen_q <= 1'b0;
        end
        OP_IOSEL: begin
          io_q     <= 1'b1;
          io_sel_q <= cpu_out[4:0];
        end
        OP_WR_LO: tmp_q[3:0] <= cpu_out[3:0];
        OP_WR_HI: tmp_q[7:4] <= cpu_out[3:0];
        default: ;
      endcase
      if (!cpu_out[7] && cpu_out[6:5] == 2'b10 && io_q && sel_ok && chan_valid)
        rd_seen_q <= 1'b1;
      if (push_req && fifo_full && !pop)
        overflow_q <= 1'b1;
    end
  end

  // Memory is never reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_int_n && op == OP_COMMIT && !io_q) mem_q[mem_idx] <= commit_word;
  end

  pdp8_bus_fifo #(
    .WIDTH (CHAN_W + WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_int_n),
    .push_i  (push_req),
    .data_i  ({io_sel_q, commit_word}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .valid_o (out_valid),
    .full_o  (fifo_full)
  );

  assign out_chan = fifo_head[CHAN_W+WORD_W-1:WORD_W];
  assign out_data = fifo_head[WORD_W-1:0];
  assign overflow = overflow_q;
  assign in_ack   = in_ack_q;

endmodule

// File: tb/tb_pdp8_bus_bridge.sv
module tb_pdp8_bus_bridge;

  localparam int IO_CH = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cpu_out;
  logic [3:0]  cpu_in;
  logic [47:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ack;
  logic        out_valid, out_ready;
  logic [11:0] out_data;
  logic [4:0]  out_chan;
  logic        fifo_full, overflow;

  pdp8_bus_bridge #(.ADDR_W(12), .IO_CH(IO_CH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_out(cpu_out), .cpu_in(cpu_in),
    .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: what the CPU has told the bridge so far.
  logic [11:0] m_addr;
  logic [7:0]  m_tmp;
  bit          m_io, m_rd, m_ovf;
  int          m_sel;
  logic [11:0] mem_m [int];
  logic [16:0] exp_q [$];
  logic [3:0]  exp_ack;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every FIFO handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("out_data", int'(out_data), int'(e[11:0]));
        check("out_chan", int'(out_chan), int'(e[16:12]));
      end
    end
  end

  task automatic model_reset();
    m_addr = '0; m_tmp = '0; m_io = 0; m_rd = 0; m_ovf = 0; m_sel = 0;
    exp_ack = '0;
    exp_q.delete();
  endtask

  // One bus cycle: apply byte, check read nibble, update model, check after edge.
  task automatic bus(input logic [7:0] v, input bit rdy);
    logic [11:0] src, w;
    logic [3:0]  enib;
    bit          known;
    cpu_out = v;
    out_ready = rdy;
    #1;
    known = 1;
    src = '0;
    if (m_io) begin
      if (m_sel < IO_CH) src = in_data[m_sel*12 +: 12];
    end else if (mem_m.exists(int'(m_addr))) begin
      src = mem_m[int'(m_addr)];
    end else begin
      known = (v[6:5] == 2'b11);
    end
    case (v[6:5])
      2'b00: enib = src[11:8];
      2'b01: enib = src[7:4];
      2'b10: enib = src[3:0];
      default: enib = 4'h0;
    endcase
    if (known) check("cpu_in", int'(cpu_in), int'(enib));

    exp_ack = '0;
    if (v[7]) begin
      if (m_io && m_rd) exp_ack[m_sel] = 1'b1;
      m_io = 0;
      m_rd = 0;
      if (v[6]) m_addr[11:6] = v[5:0];
      else      m_addr[5:0]  = v[5:0];
    end else if (v[6:5] == 2'b11) begin
      m_io = 1;
      m_sel = int'(v[4:0]);
    end else begin
      if (v[6:5] == 2'b10 && m_io && m_sel < IO_CH && in_valid[m_sel]) m_rd = 1;
      if (v[4]) begin
        case (v[6:5])
          2'b00: m_tmp[3:0] = v[3:0];
          2'b01: m_tmp[7:4] = v[3:0];
          default: begin
            w = {v[3:0], m_tmp};
            if (!m_io) mem_m[int'(m_addr)] = w;
            else if (m_sel < IO_CH) begin
              if (exp_q.size() < DEPTH || (rdy && exp_q.size() > 0))
                exp_q.push_back({5'(m_sel), w});
              else
                m_ovf = 1;
            end
          end
        endcase
      end
    end

    @(posedge clk);
    #1;
    check("in_ack", int'(in_ack), int'(exp_ack));
    check("overflow", int'(overflow), int'(m_ovf));
    check("fifo_full", int'(fifo_full), int'(exp_q.size() == DEPTH));
    check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 0; cpu_out = 8'h00; out_ready = 0; in_data = '0; in_valid = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_in_ack", int'(in_ack), 0);
    cpu_out = 8'h60; #1;
    check("rst_cpu_in_x11", int'(cpu_in), 0);
    cpu_out = 8'h00;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;

    // Memory write then nibble reads: mem[0x16A] = 0x134.
    bus(8'hC5, 0); bus(8'hAA, 0); bus(8'h14, 0); bus(8'h33, 0); bus(8'h51, 0);
    bus(8'h00, 0); bus(8'h20, 0); bus(8'h40, 0);
    check("mem_16A_model", int'(mem_m[int'(12'h16A)]), 12'h134);

    // I/O commit to channel 3, then a single pop.
    bus(8'h63, 0); bus(8'h1C, 0); bus(8'h3B, 0); bus(8'h5A, 0);
    bus(8'h00, 1); bus(8'h80, 0);

    // Channel read session with in_ack on session end.
    in_data = 48'h000_000_5A7_000;
    in_valid = 4'b0010;
    bus(8'h61, 0); bus(8'h00, 0); bus(8'h20, 0); bus(8'h40, 0);
    bus(8'h80, 0); bus(8'h00, 0);
    in_valid = '0;

    // Out-of-range channel: commit dropped, reads zero.
    bus(8'h7F, 0); bus(8'h11, 0); bus(8'h32, 0); bus(8'h53, 0);
    bus(8'h00, 0); bus(8'h20, 0); bus(8'h40, 0); bus(8'h80, 0);

    // Five commits into a depth-4 FIFO without draining, then drain.
    bus(8'h62, 0);
    for (int i = 0; i < 5; i++) bus(8'h50 | 8'(i), 0);
    for (int i = 0; i < 4; i++) bus(8'h00, 1);
    bus(8'h80, 0);

    // Reset mid-session with two FIFO entries.
    bus(8'h60, 0); bus(8'h57, 0); bus(8'h58, 0);
    #2;
    rst_n = 0;
    #1;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_overflow", int'(overflow), 0);
    model_reset();
    repeat (2) @(posedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    bus(8'hC5, 0); bus(8'hAA, 0); bus(8'h00, 0); bus(8'h20, 0); bus(8'h40, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      in_data = {16'($urandom), 32'($urandom)};
      in_valid = 4'($urandom);
      case ($urandom_range(0, 7))
        0: v = 8'hC0 | 8'($urandom_range(0, 3));
        1: v = 8'h80 | 8'($urandom_range(0, 63));
        2: v = 8'h60 | (($urandom_range(0, 5) == 0) ? 8'($urandom_range(4, 31))
                                                     : 8'($urandom_range(0, 3)));
        3: v = 8'h10 | 8'($urandom_range(0, 15));
        4: v = 8'h30 | 8'($urandom_range(0, 15));
        5, 6: v = 8'h50 | 8'($urandom_range(0, 15));
        default: v = {1'b0, 2'($urandom_range(0, 2)), 1'b0, 4'($urandom)};
      endcase
      bus(v, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 2; i++) bus(8'h00, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
